// File: rtl/wb_pkg.sv
// Shared write-back definitions: register file geometry, the write request
// record carried from the result ports to the register-file write port, and
// the per-cycle source selection used by the arbiter.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // Which source owns the write port this cycle.
  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_A    = 2'd1,
    SEL_B    = 2'd2
  } wb_sel_t;

  // x0 is hardwired to zero: a result aimed at it is consumed without a write.
  function automatic logic is_real_write(input logic [REG_ADDR_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back requests. No fall-through: an entry
// pushed at a clock edge becomes visible on pop_req in the following cycle.
// Pushes while full and pops while empty are ignored. DEPTH must be a power
// of two so the pointers wrap naturally.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wb_req_t                      push_req,
  input  logic                         pop,
  output wb_req_t                      pop_req,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_req = mem[rd_ptr];

  // Storage array: contents need no reset, occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_req;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the single-cycle pipeline result (port A) and
// buffered long-latency results (port B) onto the register-file write port
// RegWEn/AddrD/DataD, and keeps a busy scoreboard of destinations with a
// long-latency write still outstanding.
//
// Optional feature macro: WB_STARVE_GUARD_EN. When defined, a saturating
// counter tracks how long a pending B entry has lost to A; on reaching
// STARVE_LIMIT, A is refused for one cycle and B is written instead. When
// undefined, A has strict priority and a_ready is constant 1.
//
// Handshake semantics: a transfer happens on a port in exactly the cycle
// where its valid and ready are both high at the rising edge. a_ready and
// b_ready never depend on their own port's valid; b_ready is derived from
// registered FIFO occupancy only, so it stays low while the FIFO is full even
// if an entry pops in that same cycle.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic [REG_ADDR_W-1:0]       a_rd,
  input  logic [XLEN-1:0]             a_data,
  input  logic                        b_valid,
  output logic                        b_ready,
  input  logic [REG_ADDR_W-1:0]       b_rd,
  input  logic [XLEN-1:0]             b_data,
  input  logic                        iss_valid,
  input  logic [REG_ADDR_W-1:0]       iss_rd,
  output logic [XLEN-1:0]             busy,
  output logic [$clog2(DEPTH+1)-1:0]  b_count,
  output logic                        RegWEn,
  output logic [REG_ADDR_W-1:0]       AddrD,
  output logic [XLEN-1:0]             DataD
);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("wb_arbiter: DEPTH must be a power of two and at least 2");
  end
  if (STARVE_LIMIT < 1) begin : g_limit_check
    $error("wb_arbiter: STARVE_LIMIT must be at least 1");
  end

  wb_sel_t   sel;
  wb_req_t   fifo_head;
  wb_req_t   win_req;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_pop;
  logic      force_b;
  logic [XLEN-1:0] busy_next;

  // ---------------------------------------------------------------------
  // Port B buffer
  // ---------------------------------------------------------------------
  assign b_ready  = !fifo_full;
  assign fifo_pop = (sel == SEL_B);

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (b_valid && b_ready),
    .push_req ('{rd: b_rd, data: b_data}),
    .pop      (fifo_pop),
    .pop_req  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (b_count)
  );

  // ---------------------------------------------------------------------
  // Starvation guard
  // ---------------------------------------------------------------------
`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;

  assign force_b = (starve_cnt == SW'(STARVE_LIMIT)) && !fifo_empty;

  // Count A wins over a waiting B entry; any B pop restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (sel == SEL_B) begin
      starve_cnt <= '0;
    end else if (sel == SEL_A && !fifo_empty &&
                 starve_cnt != SW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  assign force_b = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Source selection: forced B, then A, then any buffered B, else idle.
  // ---------------------------------------------------------------------
  // Pick this cycle's write-port owner and the request it carries.
  always_comb begin
    sel     = SEL_IDLE;
    a_ready = 1'b1;
    win_req = '{rd: a_rd, data: a_data};
    if (force_b) begin
      a_ready = 1'b0;
      sel     = SEL_B;
      win_req = fifo_head;
    end else if (a_valid) begin
      sel     = SEL_A;
    end else if (!fifo_empty) begin
      sel     = SEL_B;
      win_req = fifo_head;
    end
  end

  // ---------------------------------------------------------------------
  // Register-file write port
  // ---------------------------------------------------------------------
  // Register the winning request; x0 targets are consumed with RegWEn low.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWEn <= 1'b0;
      AddrD  <= '0;
      DataD  <= '0;
    end else if (sel != SEL_IDLE) begin
      RegWEn <= is_real_write(win_req.rd);
      AddrD  <= win_req.rd;
      DataD  <= win_req.data;
    end else begin
      RegWEn <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Busy scoreboard
  // ---------------------------------------------------------------------
  // Clear on B pop, then set on issue so a same-cycle set wins; x0 never busy.
  always_comb begin
    busy_next = busy;
    if (sel == SEL_B) begin
      busy_next[fifo_head.rd] = 1'b0;
    end
    if (iss_valid && is_real_write(iss_rd)) begin
      busy_next[iss_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter. A cycle-level reference model (B FIFO queue, busy
// bits, optional starvation counter) predicts each cycle's write-port result,
// which is pushed to an expected queue when stimulus is driven and popped
// and compared after the clock edge. Build with +define+WB_STARVE_GUARD_EN
// to exercise the starvation guard.
module tb_wb_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int CW           = $clog2(DEPTH + 1);

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [4:0]    a_rd = '0;
  logic [31:0]   a_data = '0;
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic [4:0]    b_rd = '0;
  logic [31:0]   b_data = '0;
  logic          iss_valid = 1'b0;
  logic [4:0]    iss_rd = '0;
  logic [31:0]   busy;
  logic [CW-1:0] b_count;
  logic          RegWEn;
  logic [4:0]    AddrD;
  logic [31:0]   DataD;

  always #5 clk = ~clk;

  wb_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .busy      (busy),
    .b_count   (b_count),
    .RegWEn    (RegWEn),
    .AddrD     (AddrD),
    .DataD     (DataD)
  );

  // ---------------------------------------------------------------------
  // Scoreboard and reference model state
  // ---------------------------------------------------------------------
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [37:0] exp_q[$];     // {wen, rd, data}
  logic [36:0] fifo_m[$];    // {rd, data}
  logic [31:0] busy_m = '0;
  int          starve_m = 0;
  int          b_writes = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Driver: one clock cycle of stimulus, model update, and output compare
  // ---------------------------------------------------------------------
  task automatic step(input logic av, input logic [4:0] ard,
                      input logic [31:0] ad, input logic bv,
                      input logic [4:0] brd, input logic [31:0] bd,
                      input logic iv, input logic [4:0] ird);
    logic        exp_a_ready;
    logic        exp_b_ready;
    logic        force_m;
    logic        wr;
    logic        popped;
    logic [36:0] ent;
    int          size_before;

    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    iss_valid = iv; iss_rd = ird;
    #1;

    size_before = fifo_m.size();
    exp_b_ready = (size_before < DEPTH);
    force_m     = 1'b0;
`ifdef WB_STARVE_GUARD_EN
    force_m = (starve_m == STARVE_LIMIT) && (size_before > 0);
`endif
    exp_a_ready = !force_m;
    check("a_ready", 64'(a_ready), 64'(exp_a_ready));
    check("b_ready", 64'(b_ready), 64'(exp_b_ready));

    wr = 1'b0; popped = 1'b0; ent = '0;
    if (av && !force_m) begin
      wr  = 1'b1;
      ent = {ard, ad};
    end else if (size_before > 0) begin
      wr     = 1'b1;
      popped = 1'b1;
      ent    = fifo_m.pop_front();
      b_writes++;
    end
    if (bv && exp_b_ready) fifo_m.push_back({brd, bd});
    exp_q.push_back({wr && (ent[36:32] != 5'd0), ent});

    if (popped) busy_m[ent[36:32]] = 1'b0;
    if (iv && ird != 5'd0) busy_m[ird] = 1'b1;
    busy_m[0] = 1'b0;

    if (popped) starve_m = 0;
    else if (av && !force_m && size_before > 0 && starve_m < STARVE_LIMIT)
      starve_m++;

    @(posedge clk);
    #1;

    if (exp_q.size() == 0) begin
      check("exp_q_underflow", 64'(1), 64'(0));
    end else begin
      logic [37:0] e;
      e = exp_q.pop_front();
      check("wb_wen", 64'(RegWEn), 64'(e[37]));
      if (e[37]) check("wb_addr_data", 64'({AddrD, DataD}), 64'(e[36:0]));
    end
    check("b_count", 64'(b_count), 64'(fifo_m.size()));
    check("busy", 64'(busy), 64'(busy_m));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; iss_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fifo_m.delete();
    exp_q.delete();
    busy_m   = '0;
    starve_m = 0;
    check("rst_regwen", 64'(RegWEn), 64'(0));
    check("rst_addr",   64'(AddrD),  64'(0));
    check("rst_data",   64'(DataD),  64'(0));
    check("rst_busy",   64'(busy),   64'(0));
    check("rst_count",  64'(b_count), 64'(0));
    check("rst_a_ready", 64'(a_ready), 64'(1));
    check("rst_b_ready", 64'(b_ready), 64'(1));
  endtask

  // ---------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------
  initial begin
    int b_before;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // A-only, including back-to-back A traffic.
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    check("a_only_addr", 64'(AddrD), 64'(5));
    check("a_only_data", 64'(DataD), 64'(32'hDEADBEEF));
    for (int i = 0; i < 4; i++) step(1, 5'(i + 1), 32'(i * 3 + 1), 0, 0, 0, 0, 0);
    idle(1);

    // B through an empty FIFO with a tracked destination.
    step(0, 0, 0, 0, 0, 0, 1, 7);
    check("busy7_set", 64'(busy[7]), 64'(1));
    step(0, 0, 0, 1, 7, 32'h12345678, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("b_lat_wen_t1", 64'(RegWEn), 64'(1));
    check("b_lat_addr", 64'(AddrD), 64'(7));
    check("b_lat_data", 64'(DataD), 64'(32'h12345678));
    check("busy7_clear", 64'(busy[7]), 64'(0));
    idle(1);

    // Priority and fill: A every cycle while DEPTH+1 B pushes are offered.
    for (int i = 0; i < DEPTH + 1; i++)
      step(1, 5'(10 + i), 32'hA000 + 32'(i), 1, 5'(20 + i), 32'hB000 + 32'(i), 0, 0);
    check("fill_count", 64'(b_count), 64'(DEPTH));
    check("fill_b_ready", 64'(b_ready), 64'(0));
    idle(DEPTH + 1);

    // x0 handling on both ports and at issue.
    step(1, 0, 32'h55555555, 0, 0, 0, 1, 0);
    check("x0_a_wen", 64'(RegWEn), 64'(0));
    check("x0_iss_busy", 64'(busy), 64'(0));
    step(0, 0, 0, 1, 0, 32'h66666666, 0, 0);
    idle(2);

    // Set/clear race on rd 3.
    step(0, 0, 0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 1, 3, 32'h33333333, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 3);
    check("race_busy3", 64'(busy[3]), 64'(1));
    idle(1);

    // Continuous A with one waiting B entry (guard behaviour if enabled).
    b_before = b_writes;
    step(0, 0, 0, 1, 9, 32'h99999999, 1, 9);
    for (int i = 0; i < STARVE_LIMIT + 4; i++)
      step(1, 5'(1 + (i % 30)), 32'hC000 + 32'(i), 0, 0, 0, 0, 0);
`ifdef WB_STARVE_GUARD_EN
    check("guard_b_written", 64'(b_writes - b_before), 64'(1));
`else
    check("strict_b_held", 64'(b_count), 64'(1));
`endif
    idle(2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)));
    end
    idle(DEPTH + 2);

    // Reset mid-operation with three buffered entries and pending busy bits.
    for (int i = 0; i < 3; i++)
      step(1, 5'(1 + i), 32'(i), 1, 5'(4 + i), 32'hE0 + 32'(i), 1, 5'(4 + i));
    check("pre_rst_count", 64'(b_count), 64'(3));
    do_reset();
    idle(1);
    check("post_rst_no_write", 64'(RegWEn), 64'(0));
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter: the producer side of the register-file write port (RegWEn / AddrD / DataD). Merges results from the in-order pipeline (port A, single-cycle ALU path) and a long-latency unit (port B, loads / mul-div) onto the single write port. B results are buffered in a small FIFO. A busy scoreboard lets decode stall on registers with outstanding long-latency writes.

## Interface
Parameters:
- DEPTH, 4, port-B FIFO entries; power of two, ≥2
- STARVE_LIMIT, 8, consecutive cycles B may lose to A before the guard forces B through (only with guard compiled in)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  port A result valid
- a_ready  out  1  port A accepted this cycle when high with a_valid
- a_rd  in  5  port A destination register
- a_data  in  32  port A result
- b_valid  in  1  port B result valid
- b_ready  out  1  = !fifo_full (registered state only)
- b_rd  in  5  port B destination
- b_data  in  32  port B result
- iss_valid  in  1  long-latency op issued this cycle
- iss_rd  in  5  destination of issued op
- busy  out  32  registered scoreboard; bit r set = write to xr pending on B
- b_count  out  $clog2(DEPTH+1)  FIFO occupancy
- RegWEn  out  1  register-file write enable (registered)
- AddrD  out  5  register-file write address (registered)
- DataD  out  32  register-file write data (registered)

## Operation
- Selection, per cycle, in priority order:
  - A fires if a_valid && a_ready.
  - Otherwise B pops if the FIFO is non-empty.
  - Otherwise idle.
- a_ready = 1 except when the starvation guard forces a B pop.
- Selected entry is registered to RegWEn/AddrD/DataD. RegWEn = 1 only if the selected rd != 0; a write to x0 is consumed with RegWEn = 0.
- FIFO push on b_valid && b_ready. No fall-through: an entry pushed at edge t is poppable from cycle t+1.
- Full: b_ready = 0 even if a pop occurs the same cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged.
- Scoreboard:
  - iss_valid with iss_rd != 0 sets busy[iss_rd].
  - A B-entry pop clears busy[rd].
  - Set and clear of the same rd in the same cycle: set wins.
  - busy[0] is always 0.
- Ordering between A and B writes to the same rd is upstream's job (decode stalls on busy). The arbiter does not check it.

## Timing
- Reset values:
  - RegWEn = 0, AddrD = 0, DataD = 0
  - busy = 0, b_count = 0, FIFO empty, starve counter 0
  - a_ready = 1, b_ready = 1
- Reset asserted mid-operation discards all FIFO entries and pending busy bits. No write issues on the cycle after reset.
- Port A latency: accepted in cycle t → RegWEn/AddrD/DataD valid in cycle t+1, held for one cycle.
- Port B latency, empty FIFO and A idle: pushed in cycle t → outputs valid in cycle t+2.
- busy changes are visible the cycle after iss_valid or the pop.
- Back-to-back: one write per cycle sustained; A-only traffic never bubbles.
- FIFO pointers wrap modulo DEPTH. b_count ranges 0..DEPTH.

## Configuration
- WB_STARVE_GUARD_EN defined:
  - A saturating counter increments each cycle the FIFO is non-empty and A fires.
  - The counter resets to 0 on any B pop.
  - When the counter reaches STARVE_LIMIT, a_ready = 0 for exactly one cycle and B pops.
- WB_STARVE_GUARD_EN undefined: a_ready is constant 1, A has strict priority, and the counter is absent.

## Structure
- Shared package wb_pkg holds XLEN = 32, REG_ADDR_W = 5, and struct wb_req_t {rd, data}.
- Sub-module wb_fifo: parameterised DEPTH FIFO of wb_req_t with push/pop/full/empty/count. Reused later for the pipelined core.
- Arbiter, scoreboard and output register live in wb_arbiter.

## Test plan
- A-only: a_valid with rd = 5, data = 0xDEADBEEF in cycle t → RegWEn = 1, AddrD = 5, DataD = 0xDEADBEEF in t+1; a_ready stays 1.
- B through empty FIFO: iss_rd = 7, then b_rd = 7, data = 0x12345678 with A idle → write at t+2; busy[7] goes 1 → 0 the cycle after the pop.
- Priority and fill: A valid every cycle with DEPTH+1 B pushes → b_ready drops after 4 pushes, b_count = 4. With guard off, no B write until A stops, then 4 B writes in FIFO order.
- Guard (WB_STARVE_GUARD_EN): continuous A with one B entry → a_ready = 0 for one cycle after 8 A wins; B written there.
- x0 handling: A rd = 0 → RegWEn = 0. iss_rd = 0 → busy stays 0. B rd = 0 pops with RegWEn = 0.
- Set/clear race and reset: iss_rd = 3 in the same cycle as the B pop for rd 3 → busy[3] = 1. Assert rst with 3 FIFO entries → next cycle b_count = 0, busy = 0, RegWEn = 0.
